// File: rtl/lt24_pkg.sv
// lt24_pkg: shared constants and types for the LT24 8080-style bus sequencer.
// Bus width, DC encoding, default strobe timing and FSM state encoding.
package lt24_pkg;

  localparam int BUS_W = 16;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int DEF_WR_LOW_CYC  = 2;
  localparam int DEF_WR_HIGH_CYC = 2;
  localparam int DEF_RD_LOW_CYC  = 8;
  localparam int DEF_RD_HIGH_CYC = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_LO,
    WR_HI,
    RD_LO,
    RD_HI,
    BURST_WAIT,
    RELEASE
  } state_t;

  function automatic int max4(input int a, input int b,
                              input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lt24_phase_timer.sv
// lt24_phase_timer: down-counter shared by all strobe phases.
// Loaded on phase entry; done is high on the final cycle of the phase.
module lt24_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] len,
  output logic          done
);

  logic [CW-1:0] cnt;

  // Load len-1 on entry so a phase of length N spans N cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= len - CW'(1);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lt24_bus_sequencer.sv
// lt24_bus_sequencer: shares the LT24 parallel bus between a register path
// and a pixel burst path, generating cs_n/dc_n/wr_n/rd_n timing.
module lt24_bus_sequencer
  import lt24_pkg::*;
#(
  parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
  parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC,
  parameter int RD_LOW_CYC  = DEF_RD_LOW_CYC,
  parameter int RD_HIGH_CYC = DEF_RD_HIGH_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dc,
  input  logic        cmd_rd,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  input  logic        pix_last,
  output logic        frame_busy,
  output logic        lcd_cs_n,
  output logic        lcd_dc_n,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_d_out,
  output logic        lcd_d_oe,
  input  logic [15:0] lcd_d_in
);

  localparam int MAXC = max4(WR_LOW_CYC, WR_HIGH_CYC,
                             RD_LOW_CYC, RD_HIGH_CYC);
  localparam int CW = $clog2(MAXC + 1);

  if (WR_LOW_CYC < 1 || WR_HIGH_CYC < 1 ||
      RD_LOW_CYC < 1 || RD_HIGH_CYC < 1) begin : g_bad_timing
    $error("lt24_bus_sequencer: every phase length must be >= 1");
  end

  state_t state, next_state;

  logic [BUS_W-1:0] lat_data, n_data;
  logic lat_dc, n_dc;
  logic lat_rd, n_rd;
  logic lat_last, n_last;
  logic lock, n_lock;
  logic acc_cmd, acc_pix;
  logic t_load, t_done;
  logic [CW-1:0] t_len;
  logic n_cs_n, n_dc_n, n_wr_n, n_rd_n, n_oe;

  lt24_phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .len   (t_len),
    .done  (t_done)
  );

  // Handshakes; RELEASE also takes commands so a queued command
  // follows a burst with a single cs_n high cycle.
  always_comb begin
    cmd_ready = 1'b0;
    pix_ready = 1'b0;
    if (!reset) begin
      cmd_ready = !lock && (state == IDLE || state == RELEASE);
      pix_ready = (state == IDLE && !lock && !cmd_valid) ||
                  (state == BURST_WAIT);
    end
  end

  assign acc_cmd    = cmd_valid && cmd_ready;
  assign acc_pix    = pix_valid && pix_ready;
  assign frame_busy = lock;

  // Next state, request latches and burst lock.
  always_comb begin
    next_state = state;
    n_data = lat_data;
    n_dc   = lat_dc;
    n_rd   = lat_rd;
    n_last = lat_last;
    n_lock = lock;
    if (acc_cmd) begin
      n_data = cmd_wdata;
      n_dc   = cmd_dc;
      n_rd   = cmd_rd;
      n_last = 1'b1;
    end else if (acc_pix) begin
      n_data = pix_data;
      n_dc   = DC_DATA;
      n_rd   = 1'b0;
      n_last = pix_last;
      if (!pix_last) n_lock = 1'b1;
    end
    unique case (state)
      IDLE:
        if (acc_cmd || acc_pix) next_state = SETUP;
      SETUP:
        next_state = lat_rd ? RD_LO : WR_LO;
      WR_LO:
        if (t_done) next_state = WR_HI;
      WR_HI:
        if (t_done) begin
          if (lock && !lat_last) begin
            next_state = BURST_WAIT;
          end else begin
            next_state = RELEASE;
            n_lock = 1'b0;
          end
        end
      BURST_WAIT:
        if (acc_pix) next_state = WR_LO;
      RD_LO:
        if (t_done) next_state = RD_HI;
      RD_HI:
        if (t_done) next_state = RELEASE;
      RELEASE:
        next_state = acc_cmd ? SETUP : IDLE;
      default:
        next_state = IDLE;
    endcase
  end

  // Reload the phase timer on every state change.
  always_comb begin
    t_load = (next_state != state);
    case (next_state)
      WR_LO:   t_len = CW'(WR_LOW_CYC);
      WR_HI:   t_len = CW'(WR_HIGH_CYC);
      RD_LO:   t_len = CW'(RD_LOW_CYC);
      RD_HI:   t_len = CW'(RD_HIGH_CYC);
      default: t_len = CW'(1);
    endcase
  end

  // Pin values for the state being entered, so pins match state.
  always_comb begin
    n_cs_n = 1'b1;
    n_dc_n = 1'b1;
    n_wr_n = 1'b1;
    n_rd_n = 1'b1;
    n_oe   = 1'b0;
    case (next_state)
      SETUP: begin
        n_cs_n = 1'b0;
        n_dc_n = n_dc;
        n_oe   = !n_rd;
      end
      WR_LO: begin
        n_cs_n = 1'b0;
        n_dc_n = n_dc;
        n_wr_n = 1'b0;
        n_oe   = 1'b1;
      end
      WR_HI: begin
        n_cs_n = 1'b0;
        n_dc_n = n_dc;
        n_oe   = 1'b1;
      end
      RD_LO: begin
        n_cs_n = 1'b0;
        n_dc_n = n_dc;
        n_rd_n = 1'b0;
      end
      RD_HI: begin
        n_cs_n = 1'b0;
        n_dc_n = n_dc;
      end
      BURST_WAIT: begin
        n_cs_n = 1'b0;
        n_dc_n = DC_DATA;
        n_oe   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched request and burst lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_data <= '0;
      lat_dc   <= DC_CMD;
      lat_rd   <= 1'b0;
      lat_last <= 1'b0;
      lock     <= 1'b0;
    end else begin
      state    <= next_state;
      lat_data <= n_data;
      lat_dc   <= n_dc;
      lat_rd   <= n_rd;
      lat_last <= n_last;
      lock     <= n_lock;
    end
  end

  // Registered LCD pins and read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_cs_n  <= 1'b1;
      lcd_dc_n  <= 1'b1;
      lcd_wr_n  <= 1'b1;
      lcd_rd_n  <= 1'b1;
      lcd_d_oe  <= 1'b0;
      lcd_d_out <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      lcd_cs_n  <= n_cs_n;
      lcd_dc_n  <= n_dc_n;
      lcd_wr_n  <= n_wr_n;
      lcd_rd_n  <= n_rd_n;
      lcd_d_oe  <= n_oe;
      if (n_oe) lcd_d_out <= n_data;
      rsp_valid <= (state == RD_LO) && t_done;
      if (state == RD_LO && t_done) rsp_rdata <= lcd_d_in;
    end
  end

endmodule

// File: tb/tb_lt24_bus_sequencer.sv
// tb_lt24_bus_sequencer: directed vector table for register write/read
// plus hand sequences for bursts, arbitration and mid-burst reset.
module tb_lt24_bus_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_dc, cmd_rd;
  logic [15:0] cmd_wdata, rsp_rdata, pix_data;
  logic [15:0] lcd_d_out, lcd_d_in;
  logic rsp_valid, pix_valid, pix_ready, pix_last, frame_busy;
  logic lcd_cs_n, lcd_dc_n, lcd_wr_n, lcd_rd_n, lcd_d_oe;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lt24_bus_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dc     (cmd_dc),
    .cmd_rd     (cmd_rd),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .frame_busy (frame_busy),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_dc_n   (lcd_dc_n),
    .lcd_wr_n   (lcd_wr_n),
    .lcd_rd_n   (lcd_rd_n),
    .lcd_d_out  (lcd_d_out),
    .lcd_d_oe   (lcd_d_oe),
    .lcd_d_in   (lcd_d_in)
  );

  // flags = {cmd_ready,pix_ready,frame_busy,rsp_valid,
  //          cs_n,dc_n,wr_n,rd_n,d_oe}
  typedef struct packed {
    logic        cv;
    logic        dc;
    logic        rd;
    logic [15:0] wd;
    logic [15:0] din;
    logic [8:0]  flags;
    logic [15:0] dout;
    logic [15:0] rdata;
  } vec_t;

  vec_t tbl [24];

  logic        tr_cs [64];
  logic        tr_wr [64];
  logic        tr_dc [64];
  logic        tr_fb [64];
  logic        tr_cr [64];
  logic [15:0] tr_do [64];
  int pix_acc[$];
  int cmd_acc[$];
  logic [15:0] pbeat [4];

  function automatic vec_t mk(input logic cv, input logic dc,
                              input logic rd, input logic [15:0] wd,
                              input logic [15:0] din,
                              input logic [8:0] flags,
                              input logic [15:0] dout,
                              input logic [15:0] rdata);
    vec_t v;
    v = '{cv, dc, rd, wd, din, flags, dout, rdata};
    return v;
  endfunction

  function automatic logic [40:0] obs();
    return {cmd_ready, pix_ready, frame_busy, rsp_valid,
            lcd_cs_n, lcd_dc_n, lcd_wr_n, lcd_rd_n, lcd_d_oe,
            lcd_d_out, rsp_rdata};
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle-by-cycle driver: pixel beats from pbeat, optional command
  // raised at cycle cmd_from and held until accepted; pins are logged.
  task automatic drive(input int ncyc, input int nbeat,
                       input int cmd_from, input logic [15:0] cmd_w,
                       input logic cmd_d);
    int bi;
    bit pend;
    bi = 0;
    pend = 0;
    pix_acc.delete();
    cmd_acc.delete();
    for (int c = 0; c < ncyc; c++) begin
      pix_valid = (bi < nbeat);
      pix_data  = (bi < nbeat) ? pbeat[bi] : 16'h0;
      pix_last  = (bi == nbeat - 1);
      if (c == cmd_from) pend = 1;
      cmd_valid = pend;
      cmd_wdata = cmd_w;
      cmd_dc    = cmd_d;
      cmd_rd    = 1'b0;
      #1;
      tr_cs[c] = lcd_cs_n;
      tr_wr[c] = lcd_wr_n;
      tr_dc[c] = lcd_dc_n;
      tr_fb[c] = frame_busy;
      tr_cr[c] = cmd_ready;
      tr_do[c] = lcd_d_out;
      if (pix_valid && pix_ready) begin
        pix_acc.push_back(c);
        bi++;
      end
      if (cmd_valid && cmd_ready) begin
        cmd_acc.push_back(c);
        pend = 0;
      end
      tick();
    end
    pix_valid = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Write 0x2C as a command, then read 0x9341 (rd_n low rows 10-17).
    tbl[0] = mk(1, 0, 0, 16'h002C, 16'h1234, 9'b100011110,
                16'h0000, 16'h0);
    tbl[1] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b000000111,
                16'h002C, 16'h0);
    tbl[2] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b000000011,
                16'h002C, 16'h0);
    tbl[3] = tbl[2];
    tbl[4] = tbl[1];
    tbl[5] = tbl[1];
    tbl[6] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b100011110,
                16'h002C, 16'h0);
    tbl[7] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b110011110,
                16'h002C, 16'h0);
    tbl[8] = mk(1, 1, 1, 16'hAAAA, 16'h1234, 9'b100011110,
                16'h002C, 16'h0);
    tbl[9] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b000001110,
                16'h002C, 16'h0);
    for (int i = 10; i < 18; i++)
      tbl[i] = mk(0, 0, 0, 16'h0,
                  (i == 17) ? 16'h9341 : 16'h1234,
                  9'b000001100, 16'h002C, 16'h0);
    tbl[18] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b000101110,
                 16'h002C, 16'h9341);
    for (int i = 19; i < 22; i++)
      tbl[i] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b000001110,
                  16'h002C, 16'h9341);
    tbl[22] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b100011110,
                 16'h002C, 16'h9341);
    tbl[23] = mk(0, 0, 0, 16'h0, 16'h1234, 9'b110011110,
                 16'h002C, 16'h9341);

    reset = 1'b1;
    cmd_valid = 1'b1;
    cmd_dc = 1'b0;
    cmd_rd = 1'b0;
    cmd_wdata = 16'hFFFF;
    pix_valid = 1'b1;
    pix_data = 16'hFFFF;
    pix_last = 1'b0;
    lcd_d_in = 16'h1234;
    tick();
    tick();
    chk("reset_state", obs(), {9'b000011110, 16'h0, 16'h0});
    reset = 1'b0;
    cmd_valid = 1'b0;
    pix_valid = 1'b0;
    tick();

    for (int i = 0; i < 24; i++) begin
      cmd_valid = tbl[i].cv;
      cmd_dc    = tbl[i].dc;
      cmd_rd    = tbl[i].rd;
      cmd_wdata = tbl[i].wd;
      lcd_d_in  = tbl[i].din;
      #1;
      chk($sformatf("vec%0d", i), obs(),
          {tbl[i].flags, tbl[i].dout, tbl[i].rdata});
      tick();
    end
    cmd_valid = 1'b0;
    cmd_rd = 1'b0;

    // Four-beat burst, pix_valid held high.
    pbeat[0] = 16'hF800;
    pbeat[1] = 16'h07E0;
    pbeat[2] = 16'h001F;
    pbeat[3] = 16'hFFFF;
    drive(26, 4, -1, 16'h0, 1'b0);
    begin
      int st[$];
      int gaps;
      int dcbad;
      gaps = 0;
      dcbad = 0;
      for (int c = 1; c < 26; c++)
        if (!tr_wr[c] && tr_wr[c-1]) st.push_back(c);
      chk("burst_accept_cycles",
          {8'(qat(pix_acc, 0)), 8'(qat(pix_acc, 1)),
           8'(qat(pix_acc, 2)), 8'(qat(pix_acc, 3))},
          {8'd0, 8'd6, 8'd11, 8'd16});
      chk("burst_wr_pulses", st.size(), 4);
      chk("burst_wr_starts",
          {8'(qat(st, 0)), 8'(qat(st, 1)),
           8'(qat(st, 2)), 8'(qat(st, 3))},
          {8'd2, 8'd7, 8'd12, 8'd17});
      for (int k = 0; k < st.size() && k < 4; k++)
        chk($sformatf("burst_dout%0d", k), tr_do[st[k]], pbeat[k]);
      for (int c = 1; c <= 20; c++) if (tr_cs[c]) gaps++;
      for (int c = 0; c < 26; c++)
        if (!tr_cs[c] && !tr_dc[c]) dcbad++;
      chk("burst_cs_gaps", gaps, 0);
      chk("burst_cs_edges", {tr_cs[0], tr_cs[21]}, 2'b11);
      chk("burst_dc_n", dcbad, 0);
      chk("burst_frame_busy", {tr_fb[1], tr_fb[20], tr_fb[21]},
          3'b110);
    end

    // Command raised during a two-beat burst.
    pbeat[0] = 16'h1111;
    pbeat[1] = 16'h2222;
    drive(20, 2, 3, 16'h0055, 1'b1);
    begin
      int crhi;
      int cshi;
      crhi = 0;
      cshi = 0;
      for (int c = 3; c <= 10; c++) if (tr_cr[c]) crhi++;
      for (int c = 1; c <= 12; c++) if (tr_cs[c]) cshi++;
      chk("midburst_cmd_ready_low", crhi, 0);
      chk("midburst_cmd_accept", qat(cmd_acc, 0), 11);
      chk("midburst_pix_accept",
          {8'(qat(pix_acc, 0)), 8'(qat(pix_acc, 1))},
          {8'd0, 8'd6});
      chk("midburst_cs_gap", {8'(cshi), tr_cs[11], tr_cs[12]},
          {8'd1, 1'b1, 1'b0});
      chk("midburst_cmd_bus", {tr_do[12], tr_dc[12]},
          {16'h0055, 1'b1});
    end

    // Command and pixel raised together in IDLE.
    pbeat[0] = 16'h1234;
    drive(16, 1, 0, 16'h0011, 1'b0);
    chk("arb_cmd_first", qat(cmd_acc, 0), 0);
    chk("arb_pix_after_release", qat(pix_acc, 0), 7);
    chk("arb_cmd_bus", {tr_do[1], tr_dc[1]}, {16'h0011, 1'b0});
    chk("arb_pix_bus", {tr_cs[6], tr_cs[7], tr_do[8], tr_dc[8]},
        {1'b1, 1'b1, 16'h1234, 1'b1});

    // Reset during WR_LO of beat 2.
    pbeat[0] = 16'hF800;
    pbeat[1] = 16'h07E0;
    pbeat[2] = 16'h001F;
    pbeat[3] = 16'hFFFF;
    drive(8, 4, -1, 16'h0, 1'b0);
    chk("rst_in_wr_lo", {lcd_wr_n, frame_busy}, 2'b01);
    pix_valid = 1'b1;
    cmd_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_immediate",
        {cmd_ready, pix_ready, frame_busy, rsp_valid,
         lcd_cs_n, lcd_dc_n, lcd_wr_n, lcd_rd_n, lcd_d_oe},
        9'b000011110);
    tick();
    reset = 1'b0;
    pix_valid = 1'b0;
    cmd_valid = 1'b0;
    begin
      int act;
      act = 0;
      for (int c = 0; c < 20; c++) begin
        if (!lcd_wr_n || !lcd_cs_n || rsp_valid || frame_busy) act++;
        tick();
      end
      chk("rst_bus_quiet", act, 0);
    end
    drive(10, 1, -1, 16'h0, 1'b0);
    begin
      int lo;
      lo = 0;
      for (int c = 0; c < 10; c++) if (!tr_wr[c]) lo++;
      chk("rst_new_request", {8'(qat(pix_acc, 0)), 8'(lo)},
          {8'd0, 8'd2});
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
